// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 memory/IO bridge.
package slc3_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] IO_SW_HEX_ADDR = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BRAM_ACC = 3'd1,
    IO_ACC   = 3'd2,
    RESP     = 3'd3,
    RELEASE  = 3'd4
  } bridge_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterized two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mem_io_bridge.sv
// Bridges the SLC-3 cpu memory port to a fixed-latency BRAM and decodes one
// memory-mapped switch/hex I/O address, returning a one-cycle ready pulse.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for cpu_mem_ena; request fields latched on accept
// BRAM_ACC | bram_ena pulse issued; writes finish, reads count latency
// IO_ACC   | switch read or hex write performed this cycle
// RESP     | cpu_ready high for exactly this cycle
// RELEASE  | request still held by cpu; wait for cpu_mem_ena to drop
module mem_io_bridge
  import slc3_pkg::*;
#(
  parameter int                READ_LAT = 2,
  parameter logic [WORD_W-1:0] IO_ADDR  = IO_SW_HEX_ADDR
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [WORD_W-1:0] i_cpu_addr,
  input  logic [WORD_W-1:0] i_cpu_wdata,
  input  logic              i_cpu_mem_ena,
  input  logic              i_cpu_wr_ena,
  output logic [WORD_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ready,
  output logic [WORD_W-1:0] o_bram_addr,
  output logic [WORD_W-1:0] o_bram_wdata,
  output logic              o_bram_ena,
  output logic              o_bram_we,
  input  logic [WORD_W-1:0] i_bram_rdata,
  input  logic [WORD_W-1:0] i_sw,
  output logic [WORD_W-1:0] o_hex
);

  localparam int CNT_W = 3;

  bridge_state_t r_state;
  bridge_state_t w_state_nxt;

  logic [WORD_W-1:0] r_wdata;
  logic              r_wr;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_cpu_rdata;
  logic [WORD_W-1:0] r_hex;
  logic [WORD_W-1:0] r_bram_addr;
  logic [WORD_W-1:0] r_bram_wdata;
  logic              r_bram_ena;
  logic              r_bram_we;

  logic [WORD_W-1:0] w_sw_sync;
  logic              w_is_io;
  logic              w_capture;
  logic              w_bram_start;
  logic              w_rd_done;
  logic              w_io_rd;
  logic              w_io_wr;
  logic              w_ready;

  sync_2ff #(.WIDTH(WORD_W)) u_sw_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_sw),
    .o_q     (w_sw_sync)
  );

  assign w_is_io = (i_cpu_addr == IO_ADDR);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (i_cpu_mem_ena) w_state_nxt = w_is_io ? IO_ACC : BRAM_ACC;
      BRAM_ACC: if (r_wr || w_rd_done) w_state_nxt = RESP;
      IO_ACC:   w_state_nxt = RESP;
      RESP:     w_state_nxt = i_cpu_mem_ena ? RELEASE : IDLE;
      RELEASE:  if (!i_cpu_mem_ena) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // The counter is loaded during the bram_ena cycle, so reaching 1 lines up
  // with the cycle in which the BRAM data becomes valid.
  always_comb begin
    w_capture    = (r_state == IDLE) && i_cpu_mem_ena;
    w_bram_start = w_capture && !w_is_io;
    w_rd_done    = (r_state == BRAM_ACC) && !r_wr && !r_bram_ena &&
                   (r_cnt == CNT_W'(1));
    w_io_rd      = (r_state == IO_ACC) && !r_wr;
    w_io_wr      = (r_state == IO_ACC) && r_wr;
    w_ready      = (r_state == RESP);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wdata      <= '0;
      r_wr         <= 1'b0;
      r_cnt        <= '0;
      r_cpu_rdata  <= '0;
      r_hex        <= '0;
      r_bram_addr  <= '0;
      r_bram_wdata <= '0;
      r_bram_ena   <= 1'b0;
      r_bram_we    <= 1'b0;
    end else begin
      r_bram_ena <= w_bram_start;
      r_bram_we  <= w_bram_start && i_cpu_wr_ena;

      if (w_capture) begin
        r_wdata <= i_cpu_wdata;
        r_wr    <= i_cpu_wr_ena;
      end
      if (w_bram_start) begin
        r_bram_addr  <= i_cpu_addr;
        r_bram_wdata <= i_cpu_wdata;
      end

      if ((r_state == BRAM_ACC) && r_bram_ena) r_cnt <= CNT_W'(READ_LAT);
      else if ((r_state == BRAM_ACC) && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;

      if (w_rd_done)    r_cpu_rdata <= i_bram_rdata;
      else if (w_io_rd) r_cpu_rdata <= w_sw_sync;

      if (w_io_wr) r_hex <= r_wdata;
    end
  end

  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_cpu_ready  = w_ready;
  assign o_bram_addr  = r_bram_addr;
  assign o_bram_wdata = r_bram_wdata;
  assign o_bram_ena   = r_bram_ena;
  assign o_bram_we    = r_bram_we;
  assign o_hex        = r_hex;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: stimulus pushes expected BRAM ops and
// cpu responses from a memory-map reference model; monitors pop and compare.
module tb_mem_io_bridge;
  import slc3_pkg::*;

  localparam int RL = 2;
  localparam logic [15:0] IOA = 16'hFFFF;

  typedef struct { int cyc; logic [15:0] rdata; logic [15:0] hex; } rsp_t;
  typedef struct { int cyc; logic [15:0] addr; logic [15:0] wdata; logic we; } bop_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, sw = '0;
  logic        cpu_mem_ena = 1'b0, cpu_wr_ena = 1'b0;
  logic [15:0] cpu_rdata, bram_addr, bram_wdata, bram_rdata, hex;
  logic        cpu_ready, bram_ena, bram_we;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  rsp_t rsp_q[$];
  bop_t bop_q[$];
  rsp_t mon_r;
  bop_t mon_b;

  // reference model state
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] model_rdata = '0;
  logic [15:0] model_hex   = '0;
  logic [15:0] sw_cur      = '0;

  // BRAM emulator state
  logic [15:0] bram_mem [logic [15:0]];
  logic [15:0] pd [RL];
  logic        pv [RL];

  mem_io_bridge #(.READ_LAT(RL), .IO_ADDR(IOA)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_cpu_addr    (cpu_addr),
    .i_cpu_wdata   (cpu_wdata),
    .i_cpu_mem_ena (cpu_mem_ena),
    .i_cpu_wr_ena  (cpu_wr_ena),
    .o_cpu_rdata   (cpu_rdata),
    .o_cpu_ready   (cpu_ready),
    .o_bram_addr   (bram_addr),
    .o_bram_wdata  (bram_wdata),
    .o_bram_ena    (bram_ena),
    .o_bram_we     (bram_we),
    .i_bram_rdata  (bram_rdata),
    .i_sw          (sw),
    .o_hex         (hex)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] bram_rd(input logic [15:0] a);
    return bram_mem.exists(a) ? bram_mem[a] : init_val(a);
  endfunction

  // BRAM: data valid exactly RL cycles after the enable cycle, garbage otherwise
  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) begin
      pd[i] <= pd[i-1];
      pv[i] <= pv[i-1];
    end
    pd[0] <= bram_rd(bram_addr);
    pv[0] <= bram_ena && !bram_we;
    if (bram_ena && bram_we) bram_mem[bram_addr] = bram_wdata;
  end
  assign bram_rdata = pv[RL-1] ? pd[RL-1] : ~pd[RL-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bram_ena) begin
        if (bop_q.size() == 0) chk("bram_ena_unexpected", 1, 0);
        else begin
          mon_b = bop_q.pop_front();
          chk("bram_ena_cycle", mon_b.cyc, cyc);
          chk("bram_addr", bram_addr, mon_b.addr);
          chk("bram_we", bram_we, mon_b.we);
          chk("bram_wdata", bram_wdata, mon_b.wdata);
        end
      end else if (bram_we) chk("bram_we_without_ena", 1, 0);
      if (cpu_ready) begin
        if (rsp_q.size() == 0) chk("ready_unexpected", 1, 0);
        else begin
          mon_r = rsp_q.pop_front();
          chk("ready_cycle", cyc, mon_r.cyc);
          chk("cpu_rdata", cpu_rdata, mon_r.rdata);
          chk("hex", hex, mon_r.hex);
        end
      end
    end
  end

  // Called right after a clock edge; returns right after an edge with the
  // request dropped for the full previous cycle.
  task automatic txn(input logic [15:0] a, input logic [15:0] d, input logic wr,
                     input int hold);
    rsp_t r;
    bop_t b;
    int   lat;
    cpu_addr = a; cpu_wdata = d; cpu_wr_ena = wr; cpu_mem_ena = 1'b1;
    if (a == IOA) begin
      lat = 2;
      if (wr) model_hex = d;
      else    model_rdata = sw_cur;
    end else begin
      b.cyc = cyc + 1; b.addr = a; b.wdata = d; b.we = wr;
      bop_q.push_back(b);
      if (wr) begin
        ref_mem[a] = d;
        lat = 2;
      end else begin
        model_rdata = ref_rd(a);
        lat = RL + 2;
      end
    end
    r.cyc = cyc + lat; r.rdata = model_rdata; r.hex = model_hex;
    rsp_q.push_back(r);
    for (int i = 0; i < 20 && rsp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (rsp_q.size() != 0) begin
      chk("ready_timeout", 0, 1);
      rsp_q.delete();
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom); cpu_wr_ena = 1'($urandom);
    end
    @(posedge clk); #1;
    cpu_mem_ena = 1'b0; cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    bop_t        b;
    ref_mem[16'h0003]  = 16'h1234;
    bram_mem[16'h0003] = 16'h1234;

    idle(2);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_hex", hex, 0);
    chk("rst_bram_ena", bram_ena, 0);
    chk("rst_bram_we", bram_we, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_bram_wdata", bram_wdata, 0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    reset = 1'b0;
    idle(1);

    txn(16'h0003, 16'h0000, 1'b0, 0);
    txn(16'h0010, 16'hBEEF, 1'b1, 0);
    txn(16'h0010, 16'h0000, 1'b0, 0);
    txn(IOA, 16'h00A5, 1'b1, 0);
    sw = 16'h5A5A; sw_cur = sw;
    idle(3);
    txn(IOA, 16'h0000, 1'b0, 0);

    txn(16'h0003, 16'h0000, 1'b0, 5);
    chk("held_state_idle", 32'(dut.r_state), 32'(IDLE));
    txn(16'h0010, 16'h0000, 1'b0, 0);

    // reset while the BRAM read is still counting down
    cpu_addr = 16'h0003; cpu_wr_ena = 1'b0; cpu_mem_ena = 1'b1;
    b.cyc = cyc + 1; b.addr = 16'h0003; b.wdata = cpu_wdata; b.we = 1'b0;
    bop_q.push_back(b);
    idle(2);
    chk("midrd_state_bram_acc", 32'(dut.r_state), 32'(BRAM_ACC));
    reset = 1'b1; cpu_mem_ena = 1'b0;
    idle(1);
    reset = 1'b0;
    model_rdata = '0; model_hex = '0;
    chk("midrd_cpu_rdata", cpu_rdata, 0);
    chk("midrd_ready", cpu_ready, 0);
    chk("midrd_state", 32'(dut.r_state), 32'(IDLE));
    idle(4);
    txn(16'h0003, 16'h0000, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        sw = 16'($urandom); sw_cur = sw;
        idle(3);
      end
      a = ($urandom_range(0, 3) == 0) ? IOA : 16'($urandom_range(0, 31));
      txn(a, 16'($urandom), 1'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    if (bop_q.size() != 0) chk("bram_ops_left", bop_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
